// File: rtl/maxnet_update.sv
// maxnet_update: iterative MaxNet lateral-inhibition engine in Q(W-FRAC).FRAC.
// Each iteration applies x_k <= relu(x_k - eps * sum(x_j, j != k)). All four lanes
// are updated together at COMMIT. One multiplier is shared across the lanes.
// The downstream checker's stop is sampled only in CHECK.
// Optional feature: define MAXNET_TIMEOUT_EN to add the MAX_ITER parameter, the
// iteration limit and the timeout output.
module maxnet_update #(
   parameter int unsigned W      = 32,
   parameter int unsigned FRAC   = 16,
   parameter int unsigned ITER_W = 8
`ifdef MAXNET_TIMEOUT_EN
   ,
   parameter int unsigned MAX_ITER = 255
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [W-1:0]      x_in1,
   input  logic [W-1:0]      x_in2,
   input  logic [W-1:0]      x_in3,
   input  logic [W-1:0]      x_in4,
   input  logic [W-1:0]      eps,
   input  logic              stop,
   output logic [W-1:0]      x1,
   output logic [W-1:0]      x2,
   output logic [W-1:0]      x3,
   output logic [W-1:0]      x4,
   output logic              busy,
   output logic              done,
   output logic [ITER_W-1:0] iter_count
`ifdef MAXNET_TIMEOUT_EN
   ,
   output logic              timeout
`endif
);

   localparam int unsigned SW = W + 2;       // sum of four non-negative lanes
   localparam int unsigned PW = 2 * W;       // eps * (S - x_k) product
   localparam int unsigned QW = PW - FRAC;   // product after dropping fraction bits

   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_SUM, S_LANE0, S_LANE1, S_LANE2, S_LANE3, S_COMMIT, S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [3:0][W-1:0]  x_q;
   logic [3:0][W-1:0]  n_q;
   logic [W-1:0]       eps_q;
   logic [SW-1:0]      sum_q;

   logic               load_c, sum_c, lane_c, commit_c, finish_c, timeout_c;
   logic [1:0]         lane_sel_c;
   logic               limit_hit_c;
   logic [3:0][W-1:0]  x_in_c;
   logic [W-1:0]       x_sel_c;
   logic [SW-1:0]      diff_c;
   logic [PW-1:0]      prod_c;
   logic [QW-1:0]      p_c;
   logic [QW-1:0]      x_ext_c;
   logic [W-1:0]       n_c;

`ifdef MAXNET_TIMEOUT_EN
   logic               timeout_q;
   assign limit_hit_c = (iter_count == ITER_W'(MAX_ITER));
   assign timeout     = timeout_q;
`else
   assign limit_hit_c = 1'b0;
`endif

   assign x_in_c = {x_in4, x_in3, x_in2, x_in1};
   assign x1     = x_q[0];
   assign x2     = x_q[1];
   assign x3     = x_q[2];
   assign x4     = x_q[3];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nxt = S_CHECK;
         S_CHECK:        state_nxt = (stop || limit_hit_c) ? S_DONE : S_SUM;
         S_SUM:          state_nxt = S_LANE0;
         S_LANE0:        state_nxt = S_LANE1;
         S_LANE1:        state_nxt = S_LANE2;
         S_LANE2:        state_nxt = S_LANE3;
         S_LANE3:        state_nxt = S_COMMIT;
         S_COMMIT:       state_nxt = S_CHECK;
         default:        state_nxt = S_IDLE;
      endcase
   end

   // Per-state control strobes for the datapath
   always_comb begin
      load_c     = 1'b0;
      sum_c      = 1'b0;
      lane_c     = 1'b0;
      lane_sel_c = 2'd0;
      commit_c   = 1'b0;
      finish_c   = 1'b0;
      timeout_c  = 1'b0;
      case (state)
         S_IDLE, S_DONE: load_c = start;
         S_CHECK: begin
            finish_c  = stop | limit_hit_c;
            timeout_c = ~stop & limit_hit_c;
         end
         S_SUM:    sum_c = 1'b1;
         S_LANE0:  begin lane_c = 1'b1; lane_sel_c = 2'd0; end
         S_LANE1:  begin lane_c = 1'b1; lane_sel_c = 2'd1; end
         S_LANE2:  begin lane_c = 1'b1; lane_sel_c = 2'd2; end
         S_LANE3:  begin lane_c = 1'b1; lane_sel_c = 2'd3; end
         S_COMMIT: commit_c = 1'b1;
         default:  ;
      endcase
   end

   // Shared lane arithmetic: n = relu(x_k - ((eps * (S - x_k)) >> FRAC))
   always_comb begin
      x_sel_c = x_q[lane_sel_c];
      diff_c  = sum_q - SW'(x_sel_c);
      prod_c  = PW'(eps_q) * PW'(diff_c);
      p_c     = QW'(prod_c >> FRAC);
      x_ext_c = QW'(x_sel_c);
      n_c     = (p_c >= x_ext_c) ? '0 : W'(x_ext_c - p_c);
   end

   // Lane, shadow, sum and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         x_q        <= '0;
         n_q        <= '0;
         eps_q      <= '0;
         sum_q      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         iter_count <= '0;
`ifdef MAXNET_TIMEOUT_EN
         timeout_q  <= 1'b0;
`endif
      end else begin
         if (load_c) begin
            for (int k = 0; k < 4; k++)
               x_q[k] <= x_in_c[k][W-1] ? '0 : x_in_c[k];
            eps_q      <= eps;
            iter_count <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
         end
         if (finish_c) begin
            busy <= 1'b0;
            done <= 1'b1;
`ifdef MAXNET_TIMEOUT_EN
            timeout_q <= timeout_c;
`endif
         end
         if (sum_c)
            sum_q <= SW'(x_q[0]) + SW'(x_q[1]) + SW'(x_q[2]) + SW'(x_q[3]);
         if (lane_c)
            n_q[lane_sel_c] <= n_c;
         if (commit_c) begin
            x_q <= n_q;
            if (iter_count != {ITER_W{1'b1}})
               iter_count <= iter_count + ITER_W'(1);
         end
      end
   end

`ifndef MAXNET_TIMEOUT_EN
   logic unused_c;
   assign unused_c = timeout_c;
`endif

endmodule
